// File: rtl/hsi_pkg.sv
// Shared HSI definitions: byte width, default receive-buffer geometry and the
// FIFO entry layout used by the receive buffer.
package hsi_pkg;

  localparam int unsigned HSI_BYTE_W           = 8;
  localparam int unsigned HSI_RXBUF_DEPTH_LOG2 = 4;
  localparam int unsigned HSI_GAP_CLKS         = 1024;

  // One stored receive entry: start-of-frame tag plus the byte itself.
  typedef struct packed {
    logic                  sof;
    logic [HSI_BYTE_W-1:0] data;
  } hsi_entry_t;

endpackage

// File: rtl/hsi_gap_det.sv
// Inter-byte idle-gap detector. Counts idle clocks since the last strobe,
// saturating at GAP_CLKS. A byte that arrives while the count is saturated
// starts a new frame.
//   clk, n_rst : clock, asynchronous active-low reset
//   d_rdy      : byte strobe from the receive path
//   sof_now    : the byte strobed this cycle (if any) is a start of frame
module hsi_gap_det
  import hsi_pkg::*;
#(
  parameter int unsigned GAP_CLKS = HSI_GAP_CLKS
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_rdy,
  output logic sof_now
);

  localparam int unsigned CW = $clog2(GAP_CLKS + 1);
  localparam logic [CW-1:0] GAP_MAX = CW'(GAP_CLKS);

  logic [CW-1:0] gap_cnt;

  // Reset to saturation so the first byte after reset is a frame start.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      gap_cnt <= GAP_MAX;
    end else if (d_rdy) begin
      gap_cnt <= '0;
    end else if (gap_cnt != GAP_MAX) begin
      gap_cnt <= gap_cnt + CW'(1);
    end
  end

  assign sof_now = (gap_cnt == GAP_MAX);

endmodule

// File: rtl/hsi_rx_buf.sv
// HSI master receive buffer: first-word-fall-through FIFO of {sof, byte}
// entries with a sticky overflow flag.
//   clk, n_rst     : clock, asynchronous active-low reset
//   d, d_rdy       : received byte and its one-clock valid strobe
//   rd_en          : pop the head entry (ignored when empty)
//   ovf_clr        : clear the sticky overflow flag
//   q, q_sof       : head byte and its start-of-frame tag, 0 when empty
//   empty, full    : FIFO occupancy flags
//   level          : number of stored entries
//   ovf            : sticky, a byte was dropped because the FIFO was full
module hsi_rx_buf
  import hsi_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = HSI_RXBUF_DEPTH_LOG2,
  parameter int unsigned GAP_CLKS   = HSI_GAP_CLKS
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [HSI_BYTE_W-1:0] d,
  input  logic                  d_rdy,
  input  logic                  rd_en,
  input  logic                  ovf_clr,
  output logic [HSI_BYTE_W-1:0] q,
  output logic                  q_sof,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf
);

  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  hsi_entry_t    mem [DEPTH];
  hsi_entry_t    head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] cnt;
  logic          sof_now;
  logic          wr_go;
  logic          rd_go;
  logic          drop;

  hsi_gap_det #(
    .GAP_CLKS (GAP_CLKS)
  ) u_gap_det (
    .clk     (clk),
    .n_rst   (n_rst),
    .d_rdy   (d_rdy),
    .sof_now (sof_now)
  );

  assign empty = (cnt == '0);
  assign full  = (cnt == LW'(DEPTH));
  assign level = cnt;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign rd_go = rd_en && !empty;
  assign wr_go = d_rdy && (!full || rd_en);
  assign drop  = d_rdy && full && !rd_en;

  // Storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      mem[wr_ptr] <= '{sof: sof_now, data: d};
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_go) wr_ptr <= wr_ptr + PW'(1);
      if (rd_go) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_go, rd_go})
        2'b10:   cnt <= cnt + LW'(1);
        2'b01:   cnt <= cnt - LW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky overflow; a same-cycle drop beats the clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  // Fall-through head, forced to zero when nothing is stored.
  assign head  = mem[rd_ptr];
  assign q     = empty ? '0 : head.data;
  assign q_sof = empty ? 1'b0 : head.sof;

endmodule

// File: tb/tb_hsi_rx_buf.sv
// Self-checking bench for hsi_rx_buf: a queue-based reference model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_hsi_rx_buf;

  localparam int unsigned DL2   = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned GAP   = 8;

  logic       clk;
  logic       n_rst;
  logic [7:0] d;
  logic       d_rdy;
  logic       rd_en;
  logic       ovf_clr;
  logic [7:0] q;
  logic       q_sof;
  logic       empty;
  logic       full;
  logic [4:0] level;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  hsi_rx_buf #(
    .DEPTH_LOG2 (DL2),
    .GAP_CLKS   (GAP)
  ) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .d       (d),
    .d_rdy   (d_rdy),
    .rd_en   (rd_en),
    .ovf_clr (ovf_clr),
    .q       (q),
    .q_sof   (q_sof),
    .empty   (empty),
    .full    (full),
    .level   (level),
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queue of {sof, byte}, strobe timestamps for framing.
  logic [8:0] mq[$];
  logic       m_ovf;
  bit         have_prev;
  longint     cyc;
  longint     last_cyc;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mq.delete();
      m_ovf     = 1'b0;
      have_prev = 1'b0;
      cyc       = 0;
      last_cyc  = 0;
    end else begin
      bit sof, is_full, pop, push, dropped;
      cyc++;
      sof = 1'b0;
      if (d_rdy) begin
        sof       = !have_prev || ((cyc - last_cyc) > longint'(GAP));
        last_cyc  = cyc;
        have_prev = 1'b1;
      end
      is_full = (mq.size() == DEPTH);
      pop     = rd_en && (mq.size() != 0);
      push    = d_rdy && (!is_full || rd_en);
      dropped = d_rdy && is_full && !rd_en;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back({sof, d});
      if (dropped)      m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic [7:0] eq;
    logic       es;
    eq = 8'h00;
    es = 1'b0;
    if (mq.size() != 0) begin
      eq = mq[0][7:0];
      es = mq[0][8];
    end
    total++;
    if (q !== eq || q_sof !== es || level !== 5'(mq.size()) ||
        empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH) ||
        ovf !== m_ovf) begin
      bad++;
      $display("FAIL model t=%0t got q=%h sof=%b lvl=%0d e=%b f=%b ovf=%b want q=%h sof=%b lvl=%0d ovf=%b",
               $time, q, q_sof, level, empty, full, ovf, eq, es, mq.size(), m_ovf);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  // One clock of stimulus; inputs return to idle just after the edge.
  task automatic step(input logic r, input logic [7:0] dv, input logic re, input logic oc);
    d_rdy   = r;
    d       = dv;
    rd_en   = re;
    ovf_clr = oc;
    @(posedge clk);
    #1;
    d_rdy   = 1'b0;
    rd_en   = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    n_rst   = 1'b0;
    d       = 8'h00;
    d_rdy   = 1'b0;
    rd_en   = 1'b0;
    ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_sof", 32'(q_sof), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_ovf", 32'(ovf), 32'h0);
    n_rst = 1'b1;
    idle(1);

    // Back-to-back pair: first is a frame start, second is not.
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("wr_lat_empty", 32'(empty), 32'h0);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("pair_level", 32'(level), 32'h2);
    chk("pair_q", 32'(q), 32'hA5);
    chk("pair_sof", 32'(q_sof), 32'h1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pop_q", 32'(q), 32'h3C);
    chk("pop_sof", 32'(q_sof), 32'h0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_empty", 32'(empty), 32'h1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pop_empty_level", 32'(level), 32'h0);

    // Fill to full, then overflow.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_full", 32'(full), 32'h1);
    chk("fill_level", 32'(level), 32'd16);
    chk("fill_ovf", 32'(ovf), 32'h0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf_set", 32'(ovf), 32'h1);
    chk("ovf_level", 32'(level), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_q", 32'(q), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drained", 32'(empty), 32'h1);

    // Write and read together while full.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", 32'(ovf), 32'h0);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("wr_rd_full_level", 32'(level), 32'd16);
    chk("wr_rd_full_ovf", 32'(ovf), 32'h0);
    chk("wr_rd_full_q", 32'(q), 32'h41);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("last_entry", 32'(q), 32'h77);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("after_last", 32'(empty), 32'h1);

    // Gap boundary: 7 idle clocks is not a new frame, 8 is.
    idle(10);
    step(1'b1, 8'h11, 1'b0, 1'b0);
    idle(7);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    idle(8);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    chk("gap_sof0", 32'(q_sof), 32'h1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("gap_q1", 32'(q), 32'h22);
    chk("gap_sof1", 32'(q_sof), 32'h0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("gap_q2", 32'(q), 32'h33);
    chk("gap_sof2", 32'(q_sof), 32'h1);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Overflow coinciding with a clear keeps the flag set.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf2_set", 32'(ovf), 32'h1);
    step(1'b1, 8'hFE, 1'b0, 1'b1);
    chk("ovf_clr_lose", 32'(ovf), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr_win", 32'(ovf), 32'h0);

    // Reset mid-operation with wrapped pointers and five entries stored.
    for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd5);
    chk("pre_rst_q", 32'(q), 32'h8B);
    #1;
    n_rst = 1'b0;
    #1;
    chk("arst_empty", 32'(empty), 32'h1);
    chk("arst_level", 32'(level), 32'h0);
    chk("arst_q", 32'(q), 32'h0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("post_rst_q", 32'(q), 32'h5A);
    chk("post_rst_sof", 32'(q_sof), 32'h1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
